// File: rtl/quickq_cmd_frontend.sv
// Command front end for the QuickQ priority-queue core: buffers enqueue/dequeue commands,
// issues them one at a time as single-cycle strobes and returns one response per command.
module quickq_cmd_frontend #(
    parameter int W       = 32,
    parameter int FIFO_D  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_op,
    input  logic [W-1:0] cmd_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_op,
    output logic [W-1:0] rsp_data,
    output logic [1:0]   rsp_err,
    output logic         core_enq,
    output logic         core_deq,
    output logic [W-1:0] core_data,
    input  logic         core_ready,
    input  logic         core_done,
    input  logic         core_full,
    input  logic         core_empty,
    input  logic [W-1:0] core_dout,
    output logic         busy,
    output logic [1:0]   state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // the sender holds valid and its payload stable until that edge, and ready never waits on valid.

    localparam int AW = $clog2(FIFO_D);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_D);

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_FULL  = 2'b01;
    localparam logic [1:0] ERR_EMPTY = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPATCH = 2'd1,
        S_WAIT     = 2'd2,
        S_RESP     = 2'd3
    } state_t;

    state_t          state;
    logic [W:0]      fifo_mem [FIFO_D];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            cmd_op_r;
    logic [W-1:0]    cmd_data_r;
    logic [TW-1:0]   tmo_cnt;
    logic [TW-1:0]   tmo_next;
    logic            fifo_empty;
    logic            push;
    logic            pop;

    assign fifo_empty = (count == '0);
    // Ready comes only from the stored count, so a pop in the same cycle never frees a slot early.
    assign cmd_ready  = (count != FIFO_FULL);
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state == S_IDLE) && !fifo_empty && core_ready;
    assign tmo_next   = tmo_cnt + 1'b1;

    // Strobes are decided from the core flags seen in the dispatch cycle itself.
    assign core_enq  = (state == S_DISPATCH) && !cmd_op_r && !core_full;
    assign core_deq  = (state == S_DISPATCH) &&  cmd_op_r && !core_empty;
    assign core_data = core_enq ? cmd_data_r : '0;
    assign busy      = (state != S_IDLE) || !fifo_empty;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_op, cmd_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cmd_op_r   <= 1'b0;
            cmd_data_r <= '0;
            tmo_cnt    <= '0;
            rsp_valid  <= 1'b0;
            rsp_op     <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= ERR_OK;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        {cmd_op_r, cmd_data_r} <= fifo_mem[rd_ptr];
                        state                  <= S_DISPATCH;
                    end
                end
                S_DISPATCH: begin
                    if (!cmd_op_r && core_full) begin
                        rsp_valid <= 1'b1;
                        rsp_op    <= 1'b0;
                        rsp_data  <= '0;
                        rsp_err   <= ERR_FULL;
                        state     <= S_RESP;
                    end else if (cmd_op_r && core_empty) begin
                        rsp_valid <= 1'b1;
                        rsp_op    <= 1'b1;
                        rsp_data  <= '0;
                        rsp_err   <= ERR_EMPTY;
                        state     <= S_RESP;
                    end else begin
                        tmo_cnt <= '0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    tmo_cnt <= tmo_next;
                    // A completion arriving in the expiry cycle still yields an ok response.
                    if (core_done) begin
                        rsp_valid <= 1'b1;
                        rsp_op    <= cmd_op_r;
                        rsp_data  <= cmd_op_r ? core_dout : '0;
                        rsp_err   <= ERR_OK;
                        state     <= S_RESP;
                    end else if (tmo_next == TMO_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_op    <= cmd_op_r;
                        rsp_data  <= '0;
                        rsp_err   <= ERR_TMO;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_op    <= 1'b0;
                        rsp_data  <= '0;
                        rsp_err   <= ERR_OK;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_quickq_cmd_frontend.sv
// Directed bench for quickq_cmd_frontend: a linear sequence of command scenarios with
// hand-computed responses, strobe timing and reset behaviour.
module tb_quickq_cmd_frontend;

    localparam int W       = 32;
    localparam int FIFO_D  = 4;
    localparam int TIMEOUT = 64;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic         cmd_op = 1'b0;
    logic [W-1:0] cmd_data = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic         rsp_op;
    logic [W-1:0] rsp_data;
    logic [1:0]   rsp_err;
    logic         core_enq;
    logic         core_deq;
    logic [W-1:0] core_data;
    logic         core_ready = 1'b1;
    logic         core_done = 1'b0;
    logic         core_full = 1'b0;
    logic         core_empty = 1'b0;
    logic [W-1:0] core_dout = '0;
    logic         busy;
    logic [1:0]   state_dbg;

    quickq_cmd_frontend #(.W(W), .FIFO_D(FIFO_D), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .core_enq(core_enq), .core_deq(core_deq), .core_data(core_data),
        .core_ready(core_ready), .core_done(core_done), .core_full(core_full),
        .core_empty(core_empty), .core_dout(core_dout),
        .busy(busy), .state_dbg(state_dbg)
    );

    // scoreboard
    logic [W+2:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    bit both_seen = 1'b0;
    bit stray_seen = 1'b0;

    always begin
        @(posedge clk);
        #2;
        if (core_enq || core_deq) strobe_cnt++;
        if (core_enq && core_deq) both_seen = 1'b1;
        if ((core_enq || core_deq) && state_dbg != 2'd1) stray_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W+2:0] mk(input logic op, input logic [1:0] err, input logic [W-1:0] d);
        return {op, err, d};
    endfunction

    // driver tasks
    task automatic push_cmd(input logic op, input logic [W-1:0] d);
        int n;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("push_accept", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = '0;
    endtask

    task automatic wait_strobe(input string tag, output int cyc);
        cyc = 0;
        while (!(core_enq || core_deq) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_strobe"}, core_enq || core_deq, 1);
    endtask

    task automatic do_done(input string tag, input int delay, input logic [W-1:0] dout);
        @(negedge clk);
        chk({tag, "_pulse_end"}, {core_enq, core_deq}, 0);
        repeat (delay - 1) @(negedge clk);
        chk({tag, "_no_early_rsp"}, rsp_valid, 0);
        core_done = 1'b1;
        core_dout = dout;
        @(negedge clk);
        core_done = 1'b0;
        core_dout = '0;
    endtask

    task automatic expect_rsp(input string tag);
        logic [W+2:0] e;
        int n;
        e = exp_q.pop_front();
        n = 0;
        while (!rsp_valid && n < TIMEOUT + 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, rsp_valid, 1);
        chk({tag, "_op"}, rsp_op, e[W+2]);
        chk({tag, "_err"}, rsp_err, e[W+1:W]);
        chk({tag, "_data"}, rsp_data, e[W-1:0]);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_accepted"}, rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int snap;
        int n;
        bit quiet;

        // reset state
        #1 rst = 1'b0;
        #2;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_outputs", {rsp_valid, rsp_op, rsp_err, core_enq, core_deq, busy, state_dbg}, 0);
        chk("rst_data", {rsp_data, core_data}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 1: enqueue 0x10, done 3 cycles after strobe
        exp_q.push_back(mk(1'b0, 2'b00, 32'h0));
        push_cmd(1'b0, 32'h0000_0010);
        chk("t1_busy", busy, 1);
        wait_strobe("t1", cyc);
        chk("t1_latency", cyc, 1);
        chk("t1_enq", {core_enq, core_deq}, 2'b10);
        chk("t1_core_data", core_data, 32'h10);
        do_done("t1", 3, 32'hFFFF_FFFF);
        chk("t1_rsp_next_cycle", rsp_valid, 1);
        expect_rsp("t1");

        // 2: dequeue returning 0x5
        exp_q.push_back(mk(1'b1, 2'b00, 32'h5));
        push_cmd(1'b1, 32'hDEAD_BEEF);
        wait_strobe("t2", cyc);
        chk("t2_deq", {core_enq, core_deq}, 2'b01);
        chk("t2_core_data", core_data, 0);
        do_done("t2", 2, 32'h0000_0005);
        expect_rsp("t2");

        // 3: core empty / full rejects with no strobe
        snap = strobe_cnt;
        core_empty = 1'b1;
        exp_q.push_back(mk(1'b1, 2'b10, 32'h0));
        push_cmd(1'b1, 32'h0);
        expect_rsp("t3_empty");
        core_empty = 1'b0;
        core_full  = 1'b1;
        exp_q.push_back(mk(1'b0, 2'b01, 32'h0));
        push_cmd(1'b0, 32'h77);
        expect_rsp("t3_full");
        core_full = 1'b0;
        chk("t3_no_strobe", strobe_cnt, snap);

        // core_done while idle is ignored
        core_done = 1'b1;
        core_dout = 32'hBAD;
        @(negedge clk);
        core_done = 1'b0;
        core_dout = '0;
        @(negedge clk);
        chk("idle_done_ignored", {rsp_valid, busy}, 0);

        // 4: fill FIFO with consumer stalled, then drain in order
        core_ready = 1'b0;
        push_cmd(1'b0, 32'hA1);
        push_cmd(1'b0, 32'hA2);
        push_cmd(1'b1, 32'h0);
        push_cmd(1'b0, 32'hA4);
        chk("t4_full_ready", cmd_ready, 0);
        exp_q.push_back(mk(1'b0, 2'b00, 32'h0));
        exp_q.push_back(mk(1'b0, 2'b00, 32'h0));
        exp_q.push_back(mk(1'b1, 2'b00, 32'h33));
        exp_q.push_back(mk(1'b0, 2'b00, 32'h0));
        exp_q.push_back(mk(1'b1, 2'b00, 32'h55));
        cmd_valid = 1'b1;
        cmd_op    = 1'b1;
        cmd_data  = '0;
        core_ready = 1'b1;
        @(negedge clk);
        chk("t4_c1_strobe", {core_enq, core_data}, {1'b1, 32'hA1});
        chk("t4_slot_freed", cmd_ready, 1);
        snap = strobe_cnt;
        @(negedge clk);
        chk("t4_refilled", cmd_ready, 0);
        cmd_valid = 1'b0;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        repeat (4) @(negedge clk);
        chk("t4_rsp_held", {rsp_valid, rsp_err}, {1'b1, 2'b00});
        chk("t4_no_dispatch", strobe_cnt, snap);
        expect_rsp("t4_c1");
        wait_strobe("t4_c2", cyc);
        chk("t4_c2_gap", cyc, 1);
        chk("t4_c2_data", core_data, 32'hA2);
        do_done("t4_c2", 1, 32'h0);
        expect_rsp("t4_c2");
        wait_strobe("t4_c3", cyc);
        chk("t4_c3_deq", core_deq, 1);
        do_done("t4_c3", 2, 32'h33);
        expect_rsp("t4_c3");
        wait_strobe("t4_c4", cyc);
        chk("t4_c4_data", core_data, 32'hA4);
        do_done("t4_c4", 1, 32'h0);
        expect_rsp("t4_c4");
        wait_strobe("t4_c5", cyc);
        do_done("t4_c5", 1, 32'h55);
        expect_rsp("t4_c5");
        chk("t4_drained", busy, 0);

        // 5: timeout, then normal command
        exp_q.push_back(mk(1'b0, 2'b11, 32'h0));
        push_cmd(1'b0, 32'h99);
        wait_strobe("t5", cyc);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < TIMEOUT + 5);
        chk("t5_timeout_cycles", n, TIMEOUT);
        expect_rsp("t5_tmo");
        exp_q.push_back(mk(1'b0, 2'b00, 32'h0));
        push_cmd(1'b0, 32'h5A);
        wait_strobe("t5_next", cyc);
        chk("t5_next_data", core_data, 32'h5A);
        do_done("t5_next", 1, 32'h0);
        expect_rsp("t5_next");

        // done in the expiry cycle wins
        exp_q.push_back(mk(1'b1, 2'b00, 32'h77));
        push_cmd(1'b1, 32'h0);
        wait_strobe("t5_edge", cyc);
        do_done("t5_edge", TIMEOUT - 1, 32'h77);
        expect_rsp("t5_edge");

        // 6: reset during WAIT with two queued
        push_cmd(1'b0, 32'h1);
        push_cmd(1'b0, 32'h2);
        push_cmd(1'b1, 32'h0);
        chk("t6_in_wait", state_dbg, 2'd2);
        rst = 1'b0;
        #1;
        chk("t6_rst_ready", cmd_ready, 1);
        chk("t6_rst_outputs", {rsp_valid, core_enq, core_deq, busy, state_dbg}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        snap = strobe_cnt;
        quiet = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid || busy) quiet = 1'b0;
        end
        chk("t6_quiet", quiet, 1);
        chk("t6_no_strobe", strobe_cnt, snap);
        exp_q.push_back(mk(1'b0, 2'b00, 32'h0));
        push_cmd(1'b0, 32'h42);
        wait_strobe("t6_new", cyc);
        chk("t6_new_data", core_data, 32'h42);
        do_done("t6_new", 1, 32'h0);
        expect_rsp("t6_new");

        chk("never_both_strobes", both_seen, 0);
        chk("no_stray_strobe", stray_seen, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
